// File: rtl/accel_servo_pkg.sv
// accel_servo_pkg: shared pulse-width type, timing derivations from clock and
// servo parameters, and the tilt clamp used by both axis pipelines.
package accel_servo_pkg;

  // Width of the PWM counter and of every pulse-width value, in clk ticks.
  localparam int PW_W = 20;

  // Default build parameters (25 MHz clock, 50 Hz frame, 1-2 ms pulses).
  localparam int DEF_CLK_FREQ = 25_000_000;
  localparam int DEF_PWM_FREQ = 50;
  localparam int DEF_MIN_US   = 1000;
  localparam int DEF_MAX_US   = 2000;

  // Clock ticks per microsecond.
  function automatic int tpu_of(input int clk_freq);
    return clk_freq / 1_000_000;
  endfunction

  // Clock ticks per servo frame.
  function automatic int period_of(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  // Pulse width at zero tilt, clock ticks.
  function automatic int center_of(input int clk_freq, input int min_us, input int max_us);
    return (min_us + max_us) / 2 * tpu_of(clk_freq);
  endfunction

  // Pulse-width swing from centre to either end, clock ticks.
  function automatic int half_of(input int clk_freq, input int min_us, input int max_us);
    return (max_us - min_us) / 2 * tpu_of(clk_freq);
  endfunction

  // Saturate a raw sample to [-lim, +lim]; -32768 lands on -lim like any other
  // out-of-range negative value.
  function automatic int clamp_axis(input logic signed [15:0] s, input int lim);
    int v;
    v = int'(s);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/accel_servo_pwm.sv
// accel_servo_pwm: one servo PWM channel. The frame counter and its wrap flag
// come from the parent; this channel latches its width only at the wrap so a
// frame never sees a width change part-way through.
module accel_servo_pwm
  import accel_servo_pkg::*;
#(
  parameter int RESET_WIDTH = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wrap,
  input  logic [PW_W-1:0] cnt,
  input  logic [PW_W-1:0] shadow,
  output logic            servo,
  output logic [PW_W-1:0] pulse
);

  logic            servo_q, servo_d;
  logic [PW_W-1:0] pulse_q, pulse_d;

  // Compare against the width in force this frame; take the shadow at wrap.
  always_comb begin
    servo_d = (cnt < pulse_q);
    pulse_d = wrap ? shadow : pulse_q;
  end

  // Output and active-width registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_q <= 1'b0;
      pulse_q <= PW_W'(RESET_WIDTH);
    end else begin
      servo_q <= servo_d;
      pulse_q <= pulse_d;
    end
  end

  assign servo = servo_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/accel_servo_drive.sv
// accel_servo_drive: turns accelerometer X/Y samples into two 50 Hz hobby-servo
// PWM outputs. Per axis: clamp (t+1), block-average 2^AVG_LOG2 samples (t+2),
// scale to a shadow pulse width (t+3). Shadow widths move into the PWM channels
// only at frame wrap.
// Optional feature: define ACCEL_SERVO_DEADBAND_EN to force |avg| < DEADBAND to
// the centre width; otherwise DEADBAND has no effect.
module accel_servo_drive
  import accel_servo_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int PWM_FREQ = DEF_PWM_FREQ,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int MAX_US   = DEF_MAX_US,
  parameter int FS_LOG2  = 8,
  parameter int AVG_LOG2 = 2,
  parameter int DEADBAND = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   data_update,
  input  logic signed [15:0]     data_x,
  input  logic signed [15:0]     data_y,
  output logic                   servo_x,
  output logic                   servo_y,
  output logic        [PW_W-1:0] pulse_x,
  output logic        [PW_W-1:0] pulse_y,
  output logic                   frame_start
);

  localparam int PERIOD = period_of(CLK_FREQ, PWM_FREQ);
  localparam int CENTER = center_of(CLK_FREQ, MIN_US, MAX_US);
  localparam int HALF   = half_of(CLK_FREQ, MIN_US, MAX_US);
  localparam int FS     = 1 << FS_LOG2;
  localparam int CW     = FS_LOG2 + 2;             // clamped sample width
  localparam int AW     = CW + AVG_LOG2;           // accumulator width
  localparam int SW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NBLK   = 1 << AVG_LOG2;

`ifdef ACCEL_SERVO_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  // A zero threshold makes the deadband test unreachable.
  localparam int DB_EFF = DB_EN ? DEADBAND : 0;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // Shift ones in after release; the second stage drives the internal reset.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path (here trivially,
    // elsewhere by a default first) so no latch is inferred.
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with <= so all flops sample pre-edge values and
    // pipeline stages cannot race each other through statement order.
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // Shared frame counter.
  // ---------------------------------------------------------------------------
  logic [PW_W-1:0] cnt_q, cnt_d;
  logic            frame_start_q, frame_start_d;
  logic            wrap;

  // Count 0..PERIOD-1; wrap also flags the frame-start pulse.
  always_comb begin
    wrap          = (cnt_q == PW_W'(PERIOD - 1));
    cnt_d         = wrap ? '0 : cnt_q + PW_W'(1);
    frame_start_d = wrap;
  end

  // Frame counter and frame-start registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  // ---------------------------------------------------------------------------
  // Pipeline control shared by both axes.
  // ---------------------------------------------------------------------------
  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          last;

  // Stage valids and the per-block sample counter.
  always_comb begin
    last       = (scnt_q == SW'(NBLK - 1));
    s1_valid_d = data_update;
    s2_valid_d = s1_valid_q && last;
    scnt_d     = scnt_q;
    if (s1_valid_q) scnt_d = last ? '0 : scnt_q + SW'(1);
  end

  // Valid and sample-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      scnt_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      scnt_q     <= scnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-axis datapath: index 0 = X, 1 = Y.
  // ---------------------------------------------------------------------------
  logic [1:0][15:0]     din;
  logic [1:0][PW_W-1:0] shadow_w;

  assign din = {data_y, data_x};

  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic signed [CW-1:0] clamp_q, clamp_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] avg_q, avg_d;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] avg_eff;
    logic signed [63:0]   prod;
    logic [PW_W-1:0]      shadow_q, shadow_d;

    // Clamp, accumulate/average, and scale to a shadow width.
    always_comb begin
      clamp_d = CW'(clamp_axis(din[a], FS));

      sum   = acc_q + AW'(clamp_q);
      acc_d = acc_q;
      avg_d = avg_q;
      if (s1_valid_q) begin
        if (last) begin
          avg_d = sum >>> AVG_LOG2;
          acc_d = '0;
        end else begin
          acc_d = sum;
        end
      end

      avg_eff = avg_q;
      if (int'(avg_q) > -DB_EFF && int'(avg_q) < DB_EFF) avg_eff = '0;
      prod     = 64'(avg_eff) * 64'(HALF);
      shadow_d = shadow_q;
      if (s2_valid_q) shadow_d = PW_W'(64'(CENTER) + (prod >>> FS_LOG2));
    end

    // Axis pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        clamp_q  <= '0;
        acc_q    <= '0;
        avg_q    <= '0;
        shadow_q <= PW_W'(CENTER);
      end else begin
        clamp_q  <= clamp_d;
        acc_q    <= acc_d;
        avg_q    <= avg_d;
        shadow_q <= shadow_d;
      end
    end

    assign shadow_w[a] = shadow_q;
  end

  // ---------------------------------------------------------------------------
  // PWM channels.
  // ---------------------------------------------------------------------------
  accel_servo_pwm #(.RESET_WIDTH(CENTER)) u_pwm_x (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrap   (wrap),
    .cnt    (cnt_q),
    .shadow (shadow_w[0]),
    .servo  (servo_x),
    .pulse  (pulse_x)
  );

  accel_servo_pwm #(.RESET_WIDTH(CENTER)) u_pwm_y (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrap   (wrap),
    .cnt    (cnt_q),
    .shadow (shadow_w[1]),
    .servo  (servo_y),
    .pulse  (pulse_y)
  );

endmodule

// File: tb/tb_accel_servo_drive.sv
// tb_accel_servo_drive: table vectors, random blocks against a queue-based
// reference model, and hand sequences for the wrap-cycle and mid-frame reset
// cases. Runs with a 1 MHz clock / 400 Hz frame so a frame is 2500 cycles.
module tb_accel_servo_drive;

  localparam int CLK_FREQ = 1_000_000;
  localparam int PWM_FREQ = 400;
  localparam int PERIOD   = CLK_FREQ / PWM_FREQ;   // 2500
  localparam int CENTER   = 1500;
  localparam int HALF     = 500;
  localparam int FS       = 256;
  localparam int NAVG     = 4;
  localparam int DEADBAND = 16;
`ifdef ACCEL_SERVO_DEADBAND_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef logic [3:0][15:0] quad_t;
  typedef struct {
    string name;
    quad_t x;
    quad_t y;
    int    ex;
    int    ey;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               data_update = 1'b0;
  logic signed [15:0] data_x = '0;
  logic signed [15:0] data_y = '0;
  logic               servo_x, servo_y, frame_start;
  logic [19:0]        pulse_x, pulse_y;

  accel_servo_drive #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ),
    .MIN_US   (1000),
    .MAX_US   (2000),
    .FS_LOG2  (8),
    .AVG_LOG2 (2),
    .DEADBAND (DEADBAND)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_update (data_update),
    .data_x      (data_x),
    .data_y      (data_y),
    .servo_x     (servo_x),
    .servo_y     (servo_y),
    .pulse_x     (pulse_x),
    .pulse_y     (pulse_y),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int qx[$];
  int qy[$];
  int app_x, app_y;     // width in force during the current frame
  int nxt_x, nxt_y;     // width loaded at the next frame boundary
  int late_x, late_y;   // block finished too close to the boundary
  bit late_pend;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clampm(input int v);
    if (v > FS) return FS;
    if (v < -FS) return -FS;
    return v;
  endfunction

  function automatic int map_avg(input int avg);
    int a;
    a = avg;
    if (DB && a > -DEADBAND && a < DEADBAND) a = 0;
    return CENTER + fdiv(a * HALF, FS);
  endfunction

  function automatic quad_t rep4(input int v);
    return {4{16'(v)}};
  endfunction

  // Element 0 (first sent) is the last argument.
  function automatic quad_t mk4(input int a, input int b, input int c, input int d);
    return {16'(a), 16'(b), 16'(c), 16'(d)};
  endfunction

  task automatic model_reset();
    qx.delete();
    qy.delete();
    app_x = CENTER; app_y = CENTER;
    nxt_x = CENTER; nxt_y = CENTER;
    late_pend = 1'b0;
  endtask

  // pos = frame-counter value in the strobe cycle. The new width is ready
  // three cycles later and must exist by the last cycle of the frame.
  task automatic model_push(input int x, input int y, input int pos);
    qx.push_back(clampm(x));
    qy.push_back(clampm(y));
    if (qx.size() == NAVG) begin
      int sx, sy;
      sx = 0; sy = 0;
      foreach (qx[i]) sx += qx[i];
      foreach (qy[i]) sy += qy[i];
      sx = map_avg(fdiv(sx, NAVG));
      sy = map_avg(fdiv(sy, NAVG));
      qx.delete();
      qy.delete();
      if (pos + 3 <= PERIOD - 1) begin
        nxt_x = sx; nxt_y = sy;
      end else begin
        late_x = sx; late_y = sy; late_pend = 1'b1;
      end
    end
  endtask

  task automatic model_boundary();
    app_x = nxt_x;
    app_y = nxt_y;
    if (late_pend) begin
      nxt_x = late_x; nxt_y = late_y; late_pend = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_frame(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (frame_start !== 1'b1 && k < PERIOD + 10);
    if (frame_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no frame_start within %0d cycles", tag, PERIOD + 10);
    end
  endtask

  // Runs exactly one frame from a frame_start cycle to the next, sending n
  // strobes starting at counter value off; checks high-time and new width.
  task automatic run_frame(input string tag, input quad_t sx, input quad_t sy,
                           input int n, input int off);
    int hx, hy;
    hx = 0; hy = 0;
    for (int j = 0; j < PERIOD; j++) begin
      if (j >= off && j < off + n) begin
        data_update = 1'b1;
        data_x = sx[j-off];
        data_y = sy[j-off];
        model_push(int'($signed(sx[j-off])), int'($signed(sy[j-off])), j);
      end else begin
        data_update = 1'b0;
      end
      if (j == 1) check({tag, "_fs_width"}, frame_start, 0);
      hx += int'(servo_x);
      hy += int'(servo_y);
      tick();
    end
    data_update = 1'b0;
    check({tag, "_frame"}, frame_start, 1);
    check({tag, "_hi_x"}, hx, app_x);
    check({tag, "_hi_y"}, hy, app_y);
    model_boundary();
    check({tag, "_pw_x"}, pulse_x, app_x);
    check({tag, "_pw_y"}, pulse_y, app_y);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  vec_t tbl[8];

  initial begin
    quad_t rx, ry;
    int    off, old_x, old_y;

    tbl[0] = '{"full_pos", rep4(256),    rep4(0),     2000, 1500};
    tbl[1] = '{"clamp",    rep4(-1000),  rep4(1000),  1000, 2000};
    tbl[2] = '{"extreme",  rep4(-32768), rep4(32767), 1000, 2000};
    tbl[3] = '{"half",     mk4(0, 0, 256, 256), rep4(-128), 1750, 1250};
    tbl[4] = '{"small15",  rep4(15),     rep4(-15),   DB ? 1500 : 1529, DB ? 1500 : 1470};
    tbl[5] = '{"small16",  rep4(16),     rep4(-16),   1531, 1468};
    tbl[6] = '{"floor",    mk4(1, 0, 0, 0), mk4(-1, 0, 0, 0), 1500, DB ? 1500 : 1498};
    tbl[7] = '{"mixed",    mk4(300, 200, -300, 0), mk4(100, 100, 100, 101), 1597, 1695};

    // Reset state.
    model_reset();
    repeat (3) tick();
    check("rst_servo_x", servo_x, 0);
    check("rst_servo_y", servo_y, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pw_x", pulse_x, CENTER);
    check("rst_pw_y", pulse_y, CENTER);
    reset_n = 1'b1;
    wait_frame("init");

    // Idle frame: centre width, high for exactly CENTER cycles.
    run_frame("idle", rep4(0), rep4(0), 0, 0);

    // Table vectors, one block at the start of each frame.
    foreach (tbl[i]) begin
      run_frame(tbl[i].name, tbl[i].x, tbl[i].y, 4, 0);
      check({tbl[i].name, "_tbl_x"}, pulse_x, tbl[i].ex);
      check({tbl[i].name, "_tbl_y"}, pulse_y, tbl[i].ey);
    end

    // Random blocks anywhere in the frame, including late ones.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        rx[k] = 16'(int'($urandom_range(800)) - 400);
        ry[k] = 16'(int'($urandom_range(800)) - 400);
      end
      off = int'($urandom_range(PERIOD - 4));
      run_frame("rnd", rx, ry, 4, off);
    end
    run_frame("zero", rep4(0), rep4(0), 4, 0);

    // Shadow written in the wrap cycle: old width this frame, new one next.
    old_x = app_x;
    old_y = app_y;
    run_frame("wrap", rep4(256), rep4(-256), 4, PERIOD - 6);
    check("wrap_old_x", pulse_x, old_x);
    check("wrap_old_y", pulse_y, old_y);
    run_frame("wrap_next", rep4(0), rep4(0), 0, 0);
    check("wrap_new_x", pulse_x, 2000);
    check("wrap_new_y", pulse_y, 1000);

    // One cycle earlier: shadow ready in the wrap cycle, applied immediately.
    run_frame("early", rep4(-256), rep4(256), 4, PERIOD - 7);
    check("early_x", pulse_x, 1000);
    check("early_y", pulse_y, 2000);

    // Mid-frame reset after two samples of a block.
    for (int j = 0; j < 60; j++) begin
      if (j < 2) begin
        data_update = 1'b1;
        data_x = 16'sd256;
        data_y = -16'sd256;
        model_push(256, -256, j);
      end else begin
        data_update = 1'b0;
      end
      tick();
    end
    check("pre_rst_servo_x", servo_x, 1);
    check("pre_rst_servo_y", servo_y, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_servo_x", servo_x, 0);
    check("mid_rst_servo_y", servo_y, 0);
    check("mid_rst_pw_x", pulse_x, CENTER);
    check("mid_rst_pw_y", pulse_y, CENTER);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_frame("post_rst");

    // Two fresh samples are not a block; four are.
    run_frame("rst_part", mk4(0, 0, 256, 256), mk4(0, 0, -256, -256), 2, 0);
    check("rst_part_x", pulse_x, CENTER);
    run_frame("rst_full", rep4(0), rep4(0), 2, 0);
    check("rst_full_x", pulse_x, 1750);
    check("rst_full_y", pulse_y, 1250);
    run_frame("rst_meas", rep4(0), rep4(0), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
